// File: rtl/float_pack.sv
// rtl/float_pack.sv - float format, opcodes and arithmetic helpers for the float datapath
package float_pack;

    localparam int N_exposant = 8;
    localparam int N_mantisse = 23;
    localparam int FLOAT_W    = 1 + N_exposant + N_mantisse;
    localparam int EXP_MAX    = 2**N_exposant - 2;
    localparam int BIAS       = 2**(N_exposant-1) - 1;

    typedef struct packed {
        logic                  sign;
        logic [N_exposant-1:0] exp;
        logic [N_mantisse-1:0] mant;
    } float;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_RSVD = 2'b11
    } float_op_e;

    // No inf/NaN encodings: overflow clamps to the largest finite magnitude.
    function automatic float saturate(logic sign);
        float r;
        r.sign = sign;
        r.exp  = N_exposant'(EXP_MAX);
        r.mant = '1;
        return r;
    endfunction

    function automatic int lead_zeros(logic [N_mantisse:0] v);
        int n;
        n = N_mantisse + 1;
        for (int i = 0; i <= N_mantisse; i++) begin
            if (v[i]) n = N_mantisse - i;
        end
        return n;
    endfunction

    function automatic float float_mul(float a, float b);
        float r;
        logic [2*N_mantisse+1:0] p;
        int e;
        r = '0;
        p = {{(N_mantisse+1){1'b0}}, 1'b1, a.mant} * {{(N_mantisse+1){1'b0}}, 1'b1, b.mant};
        e = int'(a.exp) + int'(b.exp) - BIAS;
        if (p[2*N_mantisse+1]) begin
            e      = e + 1;
            r.mant = p[2*N_mantisse:N_mantisse+1];
        end else begin
            r.mant = p[2*N_mantisse-1:N_mantisse];
        end
        r.sign = a.sign ^ b.sign;
        r.exp  = e[N_exposant-1:0];
        if (a.exp == '0 || b.exp == '0 || e <= 0) r = '0;
        else if (e > EXP_MAX) r = saturate(a.sign ^ b.sign);
        return r;
    endfunction

    // Mantissas are truncated, not rounded; underflow flushes to zero.
    function automatic float float_addsub(float a, float b, logic sub);
        float y, big, sml, r;
        logic [N_mantisse:0]   mb, ms, d;
        logic [N_mantisse+1:0] s;
        int diff, e, lz;
        y      = b;
        y.sign = b.sign ^ sub;
        r      = '0;
        if ({a.exp, a.mant} >= {y.exp, y.mant}) begin
            big = a;
            sml = y;
        end else begin
            big = y;
            sml = a;
        end
        diff = int'(big.exp) - int'(sml.exp);
        mb   = {1'b1, big.mant};
        ms   = (diff > N_mantisse) ? '0 : ({1'b1, sml.mant} >> diff);
        e    = int'(big.exp);
        if (sml.exp == '0) begin
            r = big;
        end else if (big.sign == sml.sign) begin
            s = {1'b0, mb} + {1'b0, ms};
            if (s[N_mantisse+1]) begin
                e      = e + 1;
                r.mant = s[N_mantisse:1];
            end else begin
                r.mant = s[N_mantisse-1:0];
            end
            r.sign = big.sign;
            r.exp  = e[N_exposant-1:0];
            if (e > EXP_MAX) r = saturate(big.sign);
        end else begin
            d      = mb - ms;
            lz     = lead_zeros(d);
            d      = d << lz;
            e      = e - lz;
            r.sign = big.sign;
            r.exp  = e[N_exposant-1:0];
            r.mant = d[N_mantisse-1:0];
            if (mb == ms || e <= 0) r = '0;
        end
        return r;
    endfunction

    function automatic logic [1:0] float_flags(float f);
        return {(f.exp == N_exposant'(EXP_MAX)) && (&f.mant), f.exp == '0};
    endfunction

endpackage

// File: rtl/float_exec_unit.sv
// rtl/float_exec_unit.sv - combinational opcode mux over the float_pack arithmetic
module float_exec_unit
    import float_pack::*;
(
    input  float_op_e op,
    input  float      a,
    input  float      b,
    output float      res
);

    always_comb begin
        res = '0;
        case (op)
            OP_MUL:  res = float_mul(a, b);
            OP_ADD:  res = float_addsub(a, b, 1'b0);
            OP_SUB:  res = float_addsub(a, b, 1'b1);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/float_op_sequencer.sv
// rtl/float_op_sequencer.sv - single-issue command sequencer with modelled execute latency
module float_op_sequencer
    import float_pack::*;
#(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [FLOAT_W-1:0] cmd_a,
    input  logic [FLOAT_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [FLOAT_W-1:0] res_data,
    output logic [TAG_W-1:0]   res_tag,
    output logic               res_err,
    output logic               res_sat,
    output logic               res_zero,
    output logic               busy,
    output logic [15:0]        op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] cnt;
    float_op_e  op_q;
    float       a_q;
    float       b_q;
    float       exec_res;

    float_exec_unit u_exec (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (exec_res)
    );

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            a_q       <= '0;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
            res_sat   <= 1'b0;
            res_zero  <= 1'b0;
            op_count  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= float_op_e'(cmd_op);
                        a_q     <= cmd_a;
                        b_q     <= cmd_b;
                        res_tag <= cmd_tag;
                        // Reserved opcode skips execution and reports an error result.
                        if (cmd_op == OP_RSVD) begin
                            res_data  <= '0;
                            res_err   <= 1'b1;
                            res_sat   <= 1'b0;
                            res_zero  <= 1'b1;
                            res_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            cnt   <= 4'(LATENCY - 1);
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        res_data              <= exec_res;
                        {res_sat, res_zero}   <= float_flags(exec_res);
                        res_err               <= 1'b0;
                        res_valid             <= 1'b1;
                        state                 <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        op_count  <= op_count + 16'd1;
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_op_sequencer.sv
// tb/tb_float_op_sequencer.sv - self-checking bench for float_op_sequencer
module tb_float_op_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, flush, cmd_valid, res_ready;
    logic        cmd_ready, res_valid, res_err, res_sat, res_zero, busy;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b, res_data;
    logic [3:0]  cmd_tag, res_tag;
    logic [15:0] op_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] cur_exp;
    logic        chk_en;
    logic        preload_req;

    logic        m_pend, m_hold, m_err;
    logic [31:0] m_data;
    logic [3:0]  m_tag;
    logic [15:0] m_count;
    int          cyc, due;

    float_op_sequencer #(.LATENCY(LAT), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err),
        .res_sat   (res_sat),
        .res_zero  (res_zero),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] flags_of(input logic [31:0] d);
        logic [7:0] e;
        e = d[30:23];
        return {(e == 8'hFE) && (&d[22:0]), e == 8'h00};
    endfunction

    // Reference: one command in flight; result due LAT edges after accept.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0;
            m_data <= '0;   m_tag <= '0;    m_count <= '0;
            cyc <= 0;       due <= 0;
        end else begin
            cyc <= cyc + 1;
            if (preload_req) m_count <= 16'hFFFF;
            if (flush) begin
                m_pend <= 1'b0;
                m_hold <= 1'b0;
            end else if (m_hold) begin
                if (res_ready) begin
                    m_hold  <= 1'b0;
                    m_count <= m_count + 16'd1;
                end
            end else if (m_pend) begin
                if (cyc == due) begin
                    m_pend <= 1'b0;
                    m_hold <= 1'b1;
                end
            end else if (cmd_valid) begin
                m_tag <= cmd_tag;
                if (cmd_op == 2'b11) begin
                    m_data <= '0;
                    m_err  <= 1'b1;
                    m_hold <= 1'b1;
                end else begin
                    m_data <= cur_exp;
                    m_err  <= 1'b0;
                    m_pend <= 1'b1;
                    due    <= cyc + LAT;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            check("cmp_cmd_ready", cmd_ready, !(m_pend || m_hold));
            check("cmp_busy", busy, m_pend || m_hold);
            check("cmp_res_valid", res_valid, m_hold);
            check("cmp_op_count", op_count, m_count);
            if (m_hold) begin
                check("cmp_res_data", res_data, m_data);
                check("cmp_res_tag", res_tag, m_tag);
                check("cmp_res_err", res_err, m_err);
                check("cmp_res_sat", res_sat, flags_of(m_data) >> 1);
                check("cmp_res_zero", res_zero, flags_of(m_data) & 2'b01);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] expd);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            step();
            n++;
        end
        if (!cmd_ready) check("issue_wait_ready", cmd_ready, 1);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cur_exp = expd;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_a = $urandom;
        cmd_b = $urandom;
    endtask

    task automatic wait_result();
        int n = 0;
        while (!res_valid && n < 40) begin
            step();
            n++;
        end
        if (!res_valid) check("wait_res_valid", res_valid, 1);
    endtask

    task automatic collect(input int hold);
        wait_result();
        repeat (hold) step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    logic [1:0]  v_op   [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [31:0] v_a    [6] = '{32'h7F000000, 32'h00800000, 32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3FC00000};
    logic [31:0] v_b    [6] = '{32'h7F000000, 32'h00800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hBF000000};
    logic [31:0] v_res  [6] = '{32'h7F7FFFFF, 32'h00000000, 32'h40400000, 32'h40000000, 32'h00000000, 32'h3F800000};
    logic        v_sat  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_zero [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; cmd_tag = '0; cur_exp = '0;
        chk_en = 1'b1; preload_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_op_count", op_count, 0);

        issue(2'b00, 32'h40000000, 32'h40400000, 4'd5, 32'h40C00000);
        step();
        check("mul_lat_e1", res_valid, 0);
        step();
        check("mul_lat_e2", res_valid, 1);
        check("mul_data", res_data, 32'h40C00000);
        check("mul_tag", res_tag, 5);
        check("mul_err", res_err, 0);
        check("mul_flags", {res_sat, res_zero}, 2'b00);
        repeat (3) step();
        check("mul_hold_data", res_data, 32'h40C00000);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("mul_op_count", op_count, 1);
        check("mul_cmd_ready", cmd_ready, 1);

        for (int i = 0; i < 6; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 4'(i), v_res[i]);
            wait_result();
            check("vec_data", res_data, v_res[i]);
            check("vec_sat", res_sat, v_sat[i]);
            check("vec_zero", res_zero, v_zero[i]);
            collect(1);
        end

        issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 4'd9, 32'h0);
        check("rsvd_valid", res_valid, 1);
        check("rsvd_err", res_err, 1);
        check("rsvd_data", res_data, 0);
        check("rsvd_tag", res_tag, 9);
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 32'h40000000; cmd_b = 32'h40400000;
        cmd_tag = 4'd1; cur_exp = 32'h40C00000;
        step();
        res_ready = 1'b0;
        check("overlap_not_accepted", busy, 0);
        step();
        cmd_valid = 1'b0;
        check("overlap_next_accept", busy, 1);
        collect(0);
        check("count_before_flush", op_count, 9);

        issue(2'b00, 32'h40000000, 32'h40000000, 4'd3, 32'h40800000);
        flush = 1'b1; res_ready = 1'b1;
        step();
        flush = 1'b0; res_ready = 1'b0;
        check("flush_exec_valid", res_valid, 0);
        check("flush_exec_busy", busy, 0);
        check("flush_exec_count", op_count, 9);

        issue(2'b11, 32'h0, 32'h0, 4'd2, 32'h0);
        flush = 1'b1; res_ready = 1'b1;
        step();
        flush = 1'b0; res_ready = 1'b0;
        check("flush_done_valid", res_valid, 0);
        check("flush_done_ready", cmd_ready, 1);
        check("flush_done_count", op_count, 9);

        issue(2'b00, 32'h40000000, 32'h40400000, 4'd7, 32'h40C00000);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_valid", res_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", cmd_ready, 1);
        check("async_rst_count", op_count, 0);
        reset = 1'b0;
        step();

        chk_en = 1'b0;
        force dut.op_count = 16'hFFFF;
        preload_req = 1'b1;
        step();
        release dut.op_count;
        preload_req = 1'b0;
        chk_en = 1'b1;
        check("wrap_preload", op_count, 16'hFFFF);
        issue(2'b11, 32'h0, 32'h0, 4'd4, 32'h0);
        collect(0);
        check("wrap_count", op_count, 0);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
